// File: rtl/vga_scanout.sv
// vga_scanout -- raster timing generator and pixel consumer for the display path.
//
// Generates the horizontal/vertical scan counts, presents them to the sprite
// cluster as x/y, samples the cluster's colour one pixel period later and
// drives registered VGA colour and syncs that are mutually aligned.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   test_en       (only with VGA_TEST_PATTERN_EN) select 8-bar test pattern
//   x, y          current h/v counts, direct register outputs, to cluster
//   pixel         cluster colour for (x,y); R=[hi], G=[mid], B=[lo]
//   texture_lock  high while y < V_ACTIVE (texture writes blocked)
//   vga_r/g/b     colour, forced to 0 during blanking
//   hsync, vsync  active-low syncs
//   frame_start   one-clk pulse on the edge both counts wrap to 0
//
// Optional feature: define VGA_TEST_PATTERN_EN to add the test_en port and
// the built-in vertical colour bar generator.
//
// CLK_DIV must be >= 2 so the cluster's 1-cycle texture read settles before
// the sampling tick. COLOR_WIDTH must be divisible by 3.

// One colour channel output register. Instantiated once per R/G/B lane.
module vga_chan #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         active,
    input  logic         pat_sel,
    input  logic         pat_on,
    input  logic [W-1:0] pix,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (tick) begin
            if (!active)
                q <= '0;
            else if (pat_sel)
                q <= {W{pat_on}};
            else
                q <= pix;
        end
    end
endmodule

module vga_scanout #(
    parameter int CLK_DIV     = 4,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int INT_WIDTH   = 16,
    parameter int COLOR_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                     test_en,
`endif
    output logic [INT_WIDTH-1:0]     x,
    output logic [INT_WIDTH-1:0]     y,
    input  logic [COLOR_WIDTH-1:0]   pixel,
    output logic                     texture_lock,
    output logic [COLOR_WIDTH/3-1:0] vga_r,
    output logic [COLOR_WIDTH/3-1:0] vga_g,
    output logic [COLOR_WIDTH/3-1:0] vga_b,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     frame_start
);
    localparam int NUM_LANES = 3;
    localparam int CW        = COLOR_WIDTH / 3;
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef logic [INT_WIDTH-1:0] cnt_t;

    localparam cnt_t H_ACT_C  = cnt_t'(H_ACTIVE);
    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t HS_BEG   = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t V_ACT_C  = cnt_t'(V_ACTIVE);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t VS_BEG   = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Decoded view of the current raster position.
    typedef struct packed {
        logic active;
        logic hs_n;
        logic vs_n;
    } raster_t;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    cnt_t             h_cnt, v_cnt;
    logic             h_last, v_last;
    raster_t          ras;

    assign tick   = (div_cnt == DIV_LAST);
    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    // ---------------- pixel clock divider ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DIV_W'(1);
    end

    // ---------------- raster counters ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + cnt_t'(1);
            end else begin
                h_cnt <= h_cnt + cnt_t'(1);
            end
        end
    end

    // Pulse lands on the same edge that x/y become 0,0. A reset does not
    // wrap the counters, so the post-reset frame carries no pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_start <= 1'b0;
        else
            frame_start <= tick && h_last && v_last;
    end

    assign x            = h_cnt;
    assign y            = v_cnt;
    assign texture_lock = (v_cnt < V_ACT_C);

    // ---------------- decode of current counts ----------------
    always_comb begin
        ras        = '0;
        ras.active = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        ras.hs_n   = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        ras.vs_n   = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    end

    // Syncs are registered on the same tick as colour so all three stay
    // aligned, one pixel period behind x/y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (tick) begin
            hsync <= ras.hs_n;
            vsync <= ras.vs_n;
        end
    end

    // ---------------- colour source ----------------
    logic                 pat_sel;
    logic [NUM_LANES-1:0] pat_rgb;   // per-lane all-ones/zero, [2]=R [1]=G [0]=B

`ifdef VGA_TEST_PATTERN_EN
    localparam cnt_t BAR_W = cnt_t'((H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1);
    // Index 0 is the leftmost bar: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
    localparam logic [7:0][2:0] BAR_RGB = {3'b000, 3'b001, 3'b100, 3'b101,
                                           3'b010, 3'b011, 3'b110, 3'b111};
    cnt_t       bar_q;
    logic [2:0] bar;

    assign bar_q   = h_cnt / BAR_W;
    // Clamp covers H_ACTIVE not divisible by 8; blanking masks beyond that.
    assign bar     = (bar_q > cnt_t'(7)) ? 3'd7 : bar_q[2:0];
    assign pat_sel = test_en;
    assign pat_rgb = BAR_RGB[bar];
`else
    assign pat_sel = 1'b0;
    assign pat_rgb = '0;
`endif

    // ---------------- per-lane colour registers ----------------
    logic [NUM_LANES-1:0][CW-1:0] chan_in;
    logic [NUM_LANES-1:0][CW-1:0] chan_out;

    assign chan_in = pixel;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            vga_chan #(.W(CW)) u_chan (
                .clk    (clk),
                .rst    (rst),
                .tick   (tick),
                .active (ras.active),
                .pat_sel(pat_sel),
                .pat_on (pat_rgb[g]),
                .pix    (chan_in[g]),
                .q      (chan_out[g])
            );
        end
    endgenerate

    assign vga_r = chan_out[2];
    assign vga_g = chan_out[1];
    assign vga_b = chan_out[0];

endmodule

// File: tb/tb_vga_scanout.sv
// Randomized scoreboard bench for vga_scanout with a reduced raster so that
// several whole frames fit in a short run.
module tb_vga_scanout;
    localparam int CD  = 3;
    localparam int HA  = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA  = 6,  VF = 1, VS = 2, VB = 1;
    localparam int HT  = HA + HF + HS + HB;   // 24
    localparam int VT  = VA + VF + VS + VB;   // 10
    localparam int FRAME = HT * VT;           // ticks per frame
    localparam int IW  = 16;
    localparam int CWD = 12;
    localparam int BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                12'hF0F, 12'hF00, 12'h00F, 12'h000};
    localparam logic [13:0] RST_EXP = {12'h000, 1'b1, 1'b1};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CWD-1:0]  pixel = '0;
`ifdef VGA_TEST_PATTERN_EN
    logic            test_en = 1'b0;
`endif
    logic [IW-1:0]   x, y;
    logic            texture_lock;
    logic [3:0]      vga_r, vga_g, vga_b;
    logic            hsync, vsync, frame_start;

    vga_scanout #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .INT_WIDTH(IW), .COLOR_WIDTH(CWD)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
        .test_en(test_en),
`endif
        .x(x), .y(y), .pixel(pixel), .texture_lock(texture_lock),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Pixel n (counted from reset release) sits at column n%HT, line (n/HT)%VT.
    logic [13:0] q[$];
    int n_ticks = 0;
    int ex = 0, ey = 0;
    bit efs = 0;

    initial begin
        int clk_n, hx, vy, col;
        bit hs_n, vs_n;
        clk_n = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                n_ticks = 0; clk_n = 0; ex = 0; ey = 0; efs = 0;
                q.delete();
                q.push_back(RST_EXP);
            end else begin
                clk_n++;
                efs = 0;
                if (clk_n % CD == 0) begin
                    hx = n_ticks % HT;
                    vy = (n_ticks / HT) % VT;
                    if (hx < HA && vy < VA) begin
                        col = int'(pixel);
`ifdef VGA_TEST_PATTERN_EN
                        if (test_en) col = BARS[hx / (HA / 8)];
`endif
                    end else begin
                        col = 0;
                    end
                    hs_n = !(hx >= HA + HF && hx < HA + HF + HS);
                    vs_n = !(vy >= VA + VF && vy < VA + VF + VS);
                    q.push_back({col[11:0], hs_n, vs_n});
                    n_ticks++;
                    ex  = n_ticks % HT;
                    ey  = (n_ticks / HT) % VT;
                    efs = (n_ticks % FRAME == 0);
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [13:0] cur;
        cur = RST_EXP;
        forever begin
            @(negedge clk);
            while (q.size() > 0) cur = q.pop_front();
            chk("rgb_sync", 32'({vga_r, vga_g, vga_b, hsync, vsync}), 32'(cur));
            chk("x", 32'(x), ex);
            chk("y", 32'(y), ey);
            chk("texture_lock", 32'(texture_lock), 32'(ey < VA));
            chk("frame_start", 32'(frame_start), 32'(efs));
        end
    end

    // ---------------- pixel/test_en stimulus ----------------
    // Changes every clk; only the tick-edge value may matter.
    initial forever begin
        @(posedge clk);
        #2;
        pixel = CWD'($urandom);
`ifdef VGA_TEST_PATTERN_EN
        test_en = $urandom_range(0, 1) == 1;
`endif
    end

    task automatic run_until(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (n_ticks < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_ticks < target) chk(name, 32'(n_ticks), 32'(target));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;

        // Stop inside vsync with hsync low: line VA+VF, column just past sync start.
        run_until(2 * FRAME + (VA + VF) * HT + (HA + HF + 1) + 1, 4 * FRAME * CD, "reach_mid_reset");
        @(negedge clk); #2;
        chk("pre_reset_hsync_low", 32'(hsync), 32'd0);
        chk("pre_reset_vsync_low", 32'(vsync), 32'd0);
        rst = 1'b1;
        #1;
        chk("async_x", 32'(x), 32'd0);
        chk("async_y", 32'(y), 32'd0);
        chk("async_hsync", 32'(hsync), 32'd1);
        chk("async_vsync", 32'(vsync), 32'd1);
        chk("async_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("async_texture_lock", 32'(texture_lock), 32'd1);
        chk("async_frame_start", 32'(frame_start), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;

        run_until(2 * FRAME + 20, 4 * FRAME * CD, "reach_end");
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
